dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single data port of the 2R1W RAM model between two requesters: m0 (CPU LSU) and m1 (secondary master: DMA/debug).
- Uses a valid/ready request handshake and returns a registered response one cycle after acceptance.
- Supports round-robin fairness, a lock for read-modify-write sequences, a lock watchdog, and an address-window check.
- The instruction port of the RAM is not touched.

Parameters:
- MEM_BASE, 64'h0000_0000_8000_0000, first valid byte address.
- MEM_SIZE, 64'h0000_0000_0800_0000, window size in bytes; valid addresses are MEM_BASE <= addr < MEM_BASE+MEM_SIZE.
- LOCK_MAX, 16, max cycles a locked owner may idle before forced release (>=1).
- LOCK_CNT_W, 5, width of the lock watchdog counter (must hold LOCK_MAX).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- mN_req_valid  in  1  request valid (N = 0, 1; all mN ports are duplicated per master)
- mN_req_ready  out  1  request accepted this cycle when valid & ready
- mN_addr  in  64  byte address
- mN_wdata  in  64  write data
- mN_wmask  in  64  bit-granular write mask
- mN_wen  in  1  1 = write, 0 = read
- mN_lock  in  1  keep ownership after this beat
- mN_resp_valid  out  1  one-cycle response pulse
- mN_resp_rdata  out  64  read data (0 for writes and errors)
- mN_resp_err  out  1  address outside window
- dmem_en  out  1  RAM port enable
- dmem_addr  out  64  RAM byte address (passed through)
- dmem_wdata  out  64  RAM write data
- dmem_wmask  out  64  RAM write mask
- dmem_wen  out  1  RAM write enable
- dmem_rdata  in  64  RAM combinational read data
- lock_err  out  1  one-cycle pulse on watchdog release

Behaviour:
- Acceptance:
  - At most one request accepted per cycle.
  - fire_N = mN_req_valid & mN_req_ready.
  - Ready is combinational from state and valids.
- IDLE state:
  - Both valid: the master selected by pointer rr gets ready. rr = 0 favours m0.
  - One valid: that master gets ready.
  - After any fire by master i, rr <= ~i.
- LOCKED(o) state:
  - Only master o may receive ready; the other master's ready = 0.
  - rr is not updated while locked.
- Transitions:
  - IDLE -> LOCKED(i) on fire_i & mi_lock.
  - LOCKED(o) -> LOCKED(o) on fire_o & mo_lock; watchdog counter cleared.
  - LOCKED(o) -> IDLE on fire_o & ~mo_lock; rr <= ~o.
  - LOCKED(o), no fire_o: counter increments.
  - Counter == LOCK_MAX-1 with no fire_o: forced IDLE, lock_err pulses next cycle, counter cleared, rr <= ~o.
- RAM drive:
  - dmem_* carry the firing master's fields in the same cycle.
  - dmem_en = fire & in_window.
  - dmem_wen = fire & in_window & wen.
  - When dmem_en = 0: dmem_addr/wdata/wmask = 0 and dmem_wen = 0.
- Responses:
  - On fire, a registered response is produced for the firing master and appears at the next rising edge.
  - resp_valid is high for exactly one cycle.
  - Read in window: rdata = dmem_rdata sampled at that edge.
  - Write in window: rdata = 0.
  - Out of window: err = 1, rdata = 0, no RAM access.
  - Back-to-back fires give back-to-back responses. There is no response back-pressure.
- Window check:
  - Uses 64-bit unsigned compares; no wrap.
  - MEM_BASE+MEM_SIZE is computed at elaboration time and must not overflow.
- Ordering:
  - A write followed by a read to the same word on the next cycle returns the new data (the RAM writes at posedge).
- Reset (asynchronous, any state including mid-lock):
  - State = IDLE, rr = 0, counter = 0.
  - All resp_valid/resp_err/lock_err = 0, resp_rdata = 0.
  - Ready outputs follow the IDLE rules immediately after reset deassertion.

Decomposition:
- Shared package holds:
  - arb_state_e {ARB_IDLE, ARB_LOCKED}
  - mem_req_t struct (addr, wdata, wmask, wen, lock)
  - mem_resp_t struct (rdata, err)
  - MEM_BASE / MEM_SIZE defaults
- One sub-module, lock_watchdog: counter with clear/inc/expire outputs.
- The rest stays flat.

Test Plan:
- Single read: m0 reads 0x8000_0008 with the RAM holding 0x1122_3344_5566_7788 -> dmem_addr = 0x8000_0008 in the fire cycle; m0_resp_valid = 1 next cycle with rdata 0x1122334455667788, err = 0.
- Contention: both valid for 4 cycles after reset -> grants m0, m1, m0, m1; each response only on its own master's port.
- Lock: m1 fires with lock = 1 while m0 is continuously valid -> m0_req_ready = 0 until m1 fires with lock = 0; m0 is then granted on the following cycle.
- Watchdog: m0 locks, then m0_req_valid = 0 for 16 cycles -> lock_err pulses once, state returns to IDLE, m1 is granted next.
- Out of window: m1 writes 0x7FFF_FFF8 -> dmem_en = 0 and dmem_wen = 0; m1_resp_err = 1 and rdata = 0 next cycle.
- Reset while locked: assert reset mid-lock with m0 valid after release -> resp_valid = 0 and rr = 0; m0 is granted on the first cycle after reset deasserts.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and defaults for the data-memory arbiter.
// Covers the arbiter state, request/response records and window defaults.
package dmem_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] wmask;
    logic        wen;
    logic        lock;
  } mem_req_t;

  typedef struct packed {
    logic [63:0] rdata;
    logic        err;
  } mem_resp_t;

  localparam logic [63:0] DEF_MEM_BASE = 64'h0000_0000_8000_0000;
  localparam logic [63:0] DEF_MEM_SIZE = 64'h0000_0000_0800_0000;

  // Half-open window [base, limit); limit is precomputed so there is no wrap.
  function automatic logic addr_in_window(input logic [63:0] addr,
                                          input logic [63:0] base,
                                          input logic [63:0] limit);
    return (addr >= base) && (addr < limit);
  endfunction

endpackage

// File: rtl/dmem_arbiter_lock_watchdog.sv
// Idle-cycle counter for a locked owner.
// Raises expire in the cycle that would take it past LOCK_MAX idle cycles.
module dmem_arbiter_lock_watchdog #(
  parameter int LOCK_MAX   = 16,
  parameter int LOCK_CNT_W = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expire
);

  localparam logic [LOCK_CNT_W-1:0] TERM = LOCK_CNT_W'(LOCK_MAX - 1);

  logic [LOCK_CNT_W-1:0] cnt;

  assign expire = inc & ~clr & (cnt == TERM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || expire) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + LOCK_CNT_W'(1);
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the RAM data port: round-robin grant, RMW lock with
// watchdog, address-window check and a registered one-cycle response.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter logic [63:0] MEM_BASE   = DEF_MEM_BASE,
  parameter logic [63:0] MEM_SIZE   = DEF_MEM_SIZE,
  parameter int          LOCK_MAX   = 16,
  parameter int          LOCK_CNT_W = 5
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        m0_req_valid,
  output logic        m0_req_ready,
  input  logic [63:0] m0_addr,
  input  logic [63:0] m0_wdata,
  input  logic [63:0] m0_wmask,
  input  logic        m0_wen,
  input  logic        m0_lock,
  output logic        m0_resp_valid,
  output logic [63:0] m0_resp_rdata,
  output logic        m0_resp_err,

  input  logic        m1_req_valid,
  output logic        m1_req_ready,
  input  logic [63:0] m1_addr,
  input  logic [63:0] m1_wdata,
  input  logic [63:0] m1_wmask,
  input  logic        m1_wen,
  input  logic        m1_lock,
  output logic        m1_resp_valid,
  output logic [63:0] m1_resp_rdata,
  output logic        m1_resp_err,

  output logic        dmem_en,
  output logic [63:0] dmem_addr,
  output logic [63:0] dmem_wdata,
  output logic [63:0] dmem_wmask,
  output logic        dmem_wen,
  input  logic [63:0] dmem_rdata,

  output logic        lock_err
);

  localparam logic [63:0] MEM_END = MEM_BASE + MEM_SIZE;

  arb_state_e  state;
  logic        owner;
  logic        rr;
  mem_req_t    req0, req1, req_sel;
  mem_resp_t   resp0_q, resp1_q;
  logic        fire0, fire1, fire;
  logic        win;
  logic        expire;
  logic [63:0] rdata_next;
  logic        err_next;

  assign req0 = '{addr: m0_addr, wdata: m0_wdata, wmask: m0_wmask, wen: m0_wen, lock: m0_lock};
  assign req1 = '{addr: m1_addr, wdata: m1_wdata, wmask: m1_wmask, wen: m1_wen, lock: m1_lock};

  always_comb begin
    m0_req_ready = 1'b0;
    m1_req_ready = 1'b0;
    if (state == ARB_IDLE) begin
      m0_req_ready = m0_req_valid & (~m1_req_valid | ~rr);
      m1_req_ready = m1_req_valid & (~m0_req_valid | rr);
    end else begin
      m0_req_ready = m0_req_valid & ~owner;
      m1_req_ready = m1_req_valid & owner;
    end
  end

  assign fire0   = m0_req_valid & m0_req_ready;
  assign fire1   = m1_req_valid & m1_req_ready;
  assign fire    = fire0 | fire1;
  assign req_sel = fire1 ? req1 : req0;
  assign win     = addr_in_window(req_sel.addr, MEM_BASE, MEM_END);

  assign dmem_en    = fire & win;
  assign dmem_wen   = dmem_en & req_sel.wen;
  assign dmem_addr  = dmem_en ? req_sel.addr  : '0;
  assign dmem_wdata = dmem_en ? req_sel.wdata : '0;
  assign dmem_wmask = dmem_en ? req_sel.wmask : '0;

  assign rdata_next = (dmem_en & ~req_sel.wen) ? dmem_rdata : '0;
  assign err_next   = fire & ~win;

  // While locked, any fire is necessarily the owner's, so fire alone clears it.
  dmem_arbiter_lock_watchdog #(
    .LOCK_MAX   (LOCK_MAX),
    .LOCK_CNT_W (LOCK_CNT_W)
  ) u_lock_watchdog (
    .clk    (clk),
    .rst    (reset),
    .clr    (fire),
    .inc    ((state == ARB_LOCKED) & ~fire),
    .expire (expire)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ARB_IDLE;
      owner         <= 1'b0;
      rr            <= 1'b0;
      m0_resp_valid <= 1'b0;
      m1_resp_valid <= 1'b0;
      resp0_q       <= '0;
      resp1_q       <= '0;
      lock_err      <= 1'b0;
    end else begin
      m0_resp_valid <= fire0;
      m1_resp_valid <= fire1;
      resp0_q       <= fire0 ? '{rdata: rdata_next, err: err_next} : '0;
      resp1_q       <= fire1 ? '{rdata: rdata_next, err: err_next} : '0;
      lock_err      <= expire;
      case (state)
        ARB_IDLE: begin
          if (fire) begin
            rr <= ~fire1;
            if (req_sel.lock) begin
              state <= ARB_LOCKED;
              owner <= fire1;
            end
          end
        end
        ARB_LOCKED: begin
          if (fire) begin
            if (!req_sel.lock) begin
              state <= ARB_IDLE;
              rr    <= ~owner;
            end
          end else if (expire) begin
            state <= ARB_IDLE;
            rr    <= ~owner;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  assign m0_resp_rdata = resp0_q.rdata;
  assign m0_resp_err   = resp0_q.err;
  assign m1_resp_rdata = resp1_q.rdata;
  assign m1_resp_err   = resp1_q.err;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a behavioural arbitration/memory model is
// compared on every falling edge, plus literal expectations at key points.
module tb_dmem_arbiter;

  localparam logic [63:0] WIN_LO   = 64'h0000_0000_8000_0000;
  localparam logic [63:0] WIN_HI   = 64'h0000_0000_8800_0000;
  localparam int          LOCK_MAX = 16;

  logic        clk, rst;
  logic        m0_req_valid, m0_req_ready, m0_wen, m0_lock, m0_resp_valid, m0_resp_err;
  logic [63:0] m0_addr, m0_wdata, m0_wmask, m0_resp_rdata;
  logic        m1_req_valid, m1_req_ready, m1_wen, m1_lock, m1_resp_valid, m1_resp_err;
  logic [63:0] m1_addr, m1_wdata, m1_wmask, m1_resp_rdata;
  logic        dmem_en, dmem_wen, lock_err;
  logic [63:0] dmem_addr, dmem_wdata, dmem_wmask, dmem_rdata;

  int checks = 0;
  int errors = 0;

  logic [63:0] ram [256];
  logic [63:0] mdl [256];

  dmem_arbiter dut (
    .clk(clk), .reset(rst),
    .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_wmask(m0_wmask), .m0_wen(m0_wen), .m0_lock(m0_lock),
    .m0_resp_valid(m0_resp_valid), .m0_resp_rdata(m0_resp_rdata), .m0_resp_err(m0_resp_err),
    .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_wmask(m1_wmask), .m1_wen(m1_wen), .m1_lock(m1_lock),
    .m1_resp_valid(m1_resp_valid), .m1_resp_rdata(m1_resp_rdata), .m1_resp_err(m1_resp_err),
    .dmem_en(dmem_en), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_wmask(dmem_wmask), .dmem_wen(dmem_wen), .dmem_rdata(dmem_rdata),
    .lock_err(lock_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: combinational read, masked write at posedge.
  assign dmem_rdata = ram[dmem_addr[10:3]];
  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 64'h0101_0101_0101_0101 * 64'(i);
    ram[1] = 64'h1122_3344_5566_7788;
    forever begin
      @(posedge clk);
      if (dmem_en && dmem_wen)
        ram[dmem_addr[10:3]] <= (ram[dmem_addr[10:3]] & ~dmem_wmask) | (dmem_wdata & dmem_wmask);
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic m0_set(input logic v, input logic [63:0] a, input logic we,
                        input logic [63:0] wd, input logic [63:0] wm, input logic lk);
    m0_req_valid = v; m0_addr = a; m0_wen = we; m0_wdata = wd; m0_wmask = wm; m0_lock = lk;
  endtask

  task automatic m1_set(input logic v, input logic [63:0] a, input logic we,
                        input logic [63:0] wd, input logic [63:0] wm, input logic lk);
    m1_req_valid = v; m1_addr = a; m1_wen = we; m1_wdata = wd; m1_wmask = wm; m1_lock = lk;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: tracks who owns the port, whose turn it is, how long a
  // locked owner has idled, and the responses due on the next cycle.
  initial begin
    logic        m_locked, m_owner, m_rr, e_lerr;
    int          m_idle;
    logic [1:0]  e_rv, e_err;
    logic [63:0] e_rd [2];
    logic        er0, er1, fired, fid, inw, en, we, lk, n_lerr;
    logic [63:0] a, wd, wm, rd;
    m_locked = 0; m_owner = 0; m_rr = 0; m_idle = 0;
    e_rv = '0; e_err = '0; e_rd[0] = '0; e_rd[1] = '0; e_lerr = 0;
    for (int i = 0; i < 256; i++) mdl[i] = 64'h0101_0101_0101_0101 * 64'(i);
    mdl[1] = 64'h1122_3344_5566_7788;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_locked = 0; m_owner = 0; m_rr = 0; m_idle = 0;
        e_rv = '0; e_err = '0; e_rd[0] = '0; e_rd[1] = '0; e_lerr = 0;
      end
      if (!m_locked) begin
        er0 = m0_req_valid && (!m1_req_valid || m_rr == 1'b0);
        er1 = m1_req_valid && (!m0_req_valid || m_rr == 1'b1);
      end else begin
        er0 = m0_req_valid && m_owner == 1'b0;
        er1 = m1_req_valid && m_owner == 1'b1;
      end
      chk1("m0_ready", m0_req_ready, er0);
      chk1("m1_ready", m1_req_ready, er1);
      chk1("m0_resp_valid", m0_resp_valid, e_rv[0]);
      chk1("m1_resp_valid", m1_resp_valid, e_rv[1]);
      chk1("m0_resp_err", m0_resp_err, e_err[0]);
      chk1("m1_resp_err", m1_resp_err, e_err[1]);
      chk("m0_resp_rdata", m0_resp_rdata, e_rd[0]);
      chk("m1_resp_rdata", m1_resp_rdata, e_rd[1]);
      chk1("lock_err", lock_err, e_lerr);

      fired = er0 || er1;
      fid   = er1;
      a  = fid ? m1_addr  : m0_addr;
      wd = fid ? m1_wdata : m0_wdata;
      wm = fid ? m1_wmask : m0_wmask;
      we = fid ? m1_wen   : m0_wen;
      lk = fid ? m1_lock  : m0_lock;
      inw = (a >= WIN_LO) && (a < WIN_HI);
      en  = fired && inw;
      chk1("dmem_en", dmem_en, en);
      chk1("dmem_wen", dmem_wen, en && we);
      chk("dmem_addr", dmem_addr, en ? a : 64'h0);
      chk("dmem_wdata", dmem_wdata, en ? wd : 64'h0);
      chk("dmem_wmask", dmem_wmask, en ? wm : 64'h0);

      if (!rst) begin
        e_rv = {er1, er0};
        e_err = '0; e_rd[0] = '0; e_rd[1] = '0;
        if (fired) begin
          rd = (inw && !we) ? mdl[a[10:3]] : 64'h0;
          e_rd[fid]  = rd;
          e_err[fid] = !inw;
          if (inw && we) mdl[a[10:3]] = (mdl[a[10:3]] & ~wm) | (wd & wm);
        end
        n_lerr = 0;
        if (!m_locked) begin
          if (fired) begin
            m_rr = !fid;
            if (lk) begin m_locked = 1; m_owner = fid; m_idle = 0; end
          end
        end else if (fired) begin
          m_idle = 0;
          if (!lk) begin m_locked = 0; m_rr = !m_owner; end
        end else begin
          m_idle++;
          if (m_idle == LOCK_MAX) begin
            m_locked = 0; m_rr = !m_owner; m_idle = 0; n_lerr = 1;
          end
        end
        e_lerr = n_lerr;
      end
    end
  end

  initial begin
    rst = 1'b1;
    m0_set(0, '0, 0, '0, '0, 0);
    m1_set(0, '0, 0, '0, '0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk1("rst_resp_valid", m0_resp_valid, 1'b0);
    chk1("rst_lock_err", lock_err, 1'b0);
    step(); rst = 1'b0;

    // single read, then masked write and read-after-write
    m0_set(1, 64'h8000_0008, 0, '0, '0, 0);
    @(negedge clk);
    chk("rd_dmem_addr", dmem_addr, 64'h8000_0008);
    chk1("rd_ready", m0_req_ready, 1'b1);
    step(); m0_set(1, 64'h8000_0010, 1, 64'hCAFE_BABE_DEAD_BEEF, 64'h0000_0000_FFFF_FFFF, 0);
    @(negedge clk);
    chk1("rd_resp_valid", m0_resp_valid, 1'b1);
    chk("rd_resp_rdata", m0_resp_rdata, 64'h1122_3344_5566_7788);
    chk1("rd_resp_err", m0_resp_err, 1'b0);
    chk1("wr_dmem_wen", dmem_wen, 1'b1);
    step(); m0_set(1, 64'h8000_0010, 0, '0, '0, 0);
    @(negedge clk);
    chk("wr_resp_rdata", m0_resp_rdata, 64'h0);
    step(); m0_set(0, '0, 0, '0, '0, 0);
    @(negedge clk);
    chk("raw_resp_rdata", m0_resp_rdata, 64'h0202_0202_DEAD_BEEF);

    // window edges
    step(); m1_set(1, 64'h87FF_FFF8, 0, '0, '0, 0);
    @(negedge clk);
    chk1("edge_last_en", dmem_en, 1'b1);
    step(); m1_set(1, 64'h8800_0000, 0, '0, '0, 0);
    @(negedge clk);
    chk1("edge_end_en", dmem_en, 1'b0);
    step(); m1_set(0, '0, 0, '0, '0, 0);
    @(negedge clk);
    chk1("edge_end_err", m1_resp_err, 1'b1);

    // contention from a fresh reset
    step(); rst = 1'b1;
    step(); rst = 1'b0;
    m0_set(1, 64'h8000_0020, 0, '0, '0, 0);
    m1_set(1, 64'h8000_0028, 0, '0, '0, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk1("cont_r0", m0_req_ready, (i % 2) == 0);
      chk1("cont_r1", m1_req_ready, (i % 2) == 1);
      step();
    end

    // lock by m1 while m0 keeps asking
    m1_set(1, 64'h8000_0030, 1, 64'h5555, '1, 1);
    @(negedge clk); chk1("lk_a_r0", m0_req_ready, 1'b1);
    step(); @(negedge clk); chk1("lk_b_r1", m1_req_ready, 1'b1);
    step(); @(negedge clk); chk1("lk_c_r0", m0_req_ready, 1'b0);
    step(); m1_set(0, '0, 0, '0, '0, 0);
    @(negedge clk); chk1("lk_d_r0", m0_req_ready, 1'b0);
    step(); m1_set(1, 64'h8000_0030, 0, '0, '0, 0);
    @(negedge clk);
    chk1("lk_e_r0", m0_req_ready, 1'b0);
    chk1("lk_e_r1", m1_req_ready, 1'b1);
    step(); @(negedge clk);
    chk1("lk_f_r0", m0_req_ready, 1'b1);
    chk1("lk_f_r1", m1_req_ready, 1'b0);
    chk("lk_f_rdata", m1_resp_rdata, 64'h5555);

    // watchdog: m0 locks then idles
    step(); m0_set(1, 64'h8000_0040, 0, '0, '0, 1); m1_set(0, '0, 0, '0, '0, 0);
    @(negedge clk); chk1("wd_lock_r0", m0_req_ready, 1'b1);
    step(); m0_set(0, '0, 0, '0, '0, 0); m1_set(1, 64'h7FFF_FFF8, 1, 64'hFFFF, '1, 0);
    for (int i = 0; i < LOCK_MAX; i++) begin
      @(negedge clk);
      chk1("wd_hold_r1", m1_req_ready, 1'b0);
      chk1("wd_hold_lerr", lock_err, 1'b0);
      step();
    end
    @(negedge clk);
    chk1("wd_lock_err", lock_err, 1'b1);
    chk1("wd_r1", m1_req_ready, 1'b1);
    chk1("oow_dmem_en", dmem_en, 1'b0);
    chk1("oow_dmem_wen", dmem_wen, 1'b0);
    step(); m1_set(0, '0, 0, '0, '0, 0);
    @(negedge clk);
    chk1("wd_lock_err_end", lock_err, 1'b0);
    chk1("oow_resp_valid", m1_resp_valid, 1'b1);
    chk1("oow_resp_err", m1_resp_err, 1'b1);
    chk("oow_resp_rdata", m1_resp_rdata, 64'h0);

    // reset while m1 holds the lock
    step(); m1_set(1, 64'h8000_0048, 0, '0, '0, 1);
    @(negedge clk); chk1("rl_lock_r1", m1_req_ready, 1'b1);
    step(); m0_set(1, 64'h8000_0050, 0, '0, '0, 0);
    @(negedge clk); chk1("rl_held_r0", m0_req_ready, 1'b0);
    step(); rst = 1'b1;
    @(negedge clk);
    chk1("rl_rst_resp", m1_resp_valid, 1'b0);
    chk1("rl_rst_r0", m0_req_ready, 1'b1);
    step(); rst = 1'b0;
    @(negedge clk);
    chk1("rl_post_r0", m0_req_ready, 1'b1);
    chk1("rl_post_r1", m1_req_ready, 1'b0);
    step(); m0_set(0, '0, 0, '0, '0, 0); m1_set(0, '0, 0, '0, '0, 0);
    @(negedge clk);
    chk1("rl_resp_valid", m0_resp_valid, 1'b1);
    chk("rl_resp_rdata", m0_resp_rdata, 64'h0A0A_0A0A_0A0A_0A0A);

    step(); step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
